x_ramb16_s4_arb: RTL and testbench

Two-requester arbiter and sequencer for one port of an X_RAMB16_S4_S4 (4096 x 4-bit) block RAM. It shares the port between two clients with round-robin fairness and routes 1-cycle-latency read data back to the owning client. It optionally scrubs the whole RAM to a known value after reset. It sits directly in front of RAM port A or B; the RAM's SSR input is tied low by the integrator.

---
 rtl/x_ramb16_s4_arb.sv | 160 ++++++++++++++++
 tb/tb_x_ramb16_s4_arb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/x_ramb16_s4_arb.sv
// x_ramb16_s4_arb: two-client round-robin arbiter and read-response router
// for one 4096 x 4-bit port of an X_RAMB16_S4_S4 block RAM.
// Optional feature: define X_RAMB16_ARB_SCRUB_EN to write SCRUB_VAL to
// addresses 0..SCRUB_LAST after every reset (BUSY high while scrubbing).
module x_ramb16_s4_arb #(
  parameter logic [3:0]  SCRUB_VAL  = 4'h0,
  parameter logic [11:0] SCRUB_LAST = 12'hFFF
) (
  input  logic        CLK,
  input  logic        SSR,
  input  logic        REQ0_VALID,
  output logic        REQ0_READY,
  input  logic        REQ0_WE,
  input  logic [11:0] REQ0_ADDR,
  input  logic [3:0]  REQ0_DI,
  input  logic        REQ1_VALID,
  output logic        REQ1_READY,
  input  logic        REQ1_WE,
  input  logic [11:0] REQ1_ADDR,
  input  logic [3:0]  REQ1_DI,
  output logic        RSP0_VALID,
  output logic        RSP1_VALID,
  output logic [3:0]  RSP_DATA,
  output logic        RAM_EN,
  output logic        RAM_WE,
  output logic [11:0] RAM_ADDR,
  output logic [3:0]  RAM_DI,
  input  logic [3:0]  RAM_DO,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_SCRUB = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t state, state_next;

  logic        last_grant;   // 1 = client 1 was granted most recently
  logic        grant0, grant1, accept;
  logic        sel_id, sel_we;
  logic [11:0] sel_addr;
  logic [3:0]  sel_di;
  logic        tag0_valid, tag0_id, tag1_valid, tag1_id;

`ifdef X_RAMB16_ARB_SCRUB_EN
  logic [11:0] scrub_cnt;
`endif

  // State register; SSR forces RST from any state.
  // NOTE: sequential logic uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (SSR) state <= ST_RST;
    else     state <= state_next;
  end

  // Next-state decode and round-robin grant.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state)
      ST_RST: begin
`ifdef X_RAMB16_ARB_SCRUB_EN
        state_next = ST_SCRUB;
`else
        state_next = ST_RUN;
`endif
      end
      ST_SCRUB: begin
`ifdef X_RAMB16_ARB_SCRUB_EN
        if (scrub_cnt == SCRUB_LAST) state_next = ST_RUN;
`else
        state_next = ST_RUN;
`endif
      end
      ST_RUN: begin
        // Client 0 wins when alone or when client 1 had the last grant.
        if (REQ0_VALID && (!REQ1_VALID || last_grant)) grant0 = 1'b1;
        else if (REQ1_VALID)                           grant1 = 1'b1;
      end
      default: state_next = ST_RST;
    endcase
  end

  assign REQ0_READY = grant0;
  assign REQ1_READY = grant1;
  assign accept     = grant0 | grant1;
  assign sel_id     = grant1;
  assign sel_we     = grant1 ? REQ1_WE   : REQ0_WE;
  assign sel_addr   = grant1 ? REQ1_ADDR : REQ0_ADDR;
  assign sel_di     = grant1 ? REQ1_DI   : REQ0_DI;

`ifdef X_RAMB16_ARB_SCRUB_EN
  // Scrub address counter: runs only while in SCRUB, restarts at 0 otherwise.
  always_ff @(posedge CLK) begin
    if (SSR || state != ST_SCRUB) scrub_cnt <= '0;
    else                          scrub_cnt <= scrub_cnt + 12'd1;
  end

  assign BUSY = (state != ST_RUN);
`else
  assign BUSY = 1'b0;
  // Parameters only matter to the scrub engine; fold them so they stay referenced.
  logic unused_params;
  assign unused_params = ^{SCRUB_VAL, SCRUB_LAST};
`endif

  // RAM command register, grant pointer, read-tag pipe and response register.
  // NOTE: all control state is cleared on SSR, including the tag pipe, so a
  // read in flight at reset never produces a response.
  always_ff @(posedge CLK) begin
    if (SSR) begin
      RAM_EN     <= 1'b0;
      RAM_WE     <= 1'b0;
      RAM_ADDR   <= '0;
      RAM_DI     <= '0;
      last_grant <= 1'b1;
      tag0_valid <= 1'b0;
      tag0_id    <= 1'b0;
      tag1_valid <= 1'b0;
      tag1_id    <= 1'b0;
      RSP0_VALID <= 1'b0;
      RSP1_VALID <= 1'b0;
      RSP_DATA   <= '0;
    end else begin
      RAM_EN <= 1'b0;
      RAM_WE <= 1'b0;
`ifdef X_RAMB16_ARB_SCRUB_EN
      if (state == ST_SCRUB) begin
        RAM_EN   <= 1'b1;
        RAM_WE   <= 1'b1;
        RAM_ADDR <= scrub_cnt;
        RAM_DI   <= SCRUB_VAL;
      end
`endif
      // Grants are only ever raised in RUN, so this never collides with scrub.
      if (accept) begin
        RAM_EN     <= 1'b1;
        RAM_WE     <= sel_we;
        RAM_ADDR   <= sel_addr;
        RAM_DI     <= sel_di;
        last_grant <= sel_id;
      end
      // Stage 0 covers the RAM command cycle, stage 1 the RAM output cycle.
      tag0_valid <= accept & ~sel_we;
      tag0_id    <= sel_id;
      tag1_valid <= tag0_valid;
      tag1_id    <= tag0_id;
      RSP0_VALID <= tag1_valid & ~tag1_id;
      RSP1_VALID <= tag1_valid &  tag1_id;
      if (tag1_valid) RSP_DATA <= RAM_DO;
    end
  end

endmodule

// File: tb/tb_x_ramb16_s4_arb.sv
// Self-checking bench for x_ramb16_s4_arb with a behavioural write-first RAM.
// Honours X_RAMB16_ARB_SCRUB_EN the same way the design does.
module tb_x_ramb16_s4_arb;

  logic        clk = 1'b0;
  logic        ssr;
  logic        req0_valid, req0_ready, req0_we;
  logic [11:0] req0_addr;
  logic [3:0]  req0_di;
  logic        req1_valid, req1_ready, req1_we;
  logic [11:0] req1_addr;
  logic [3:0]  req1_di;
  logic        rsp0_valid, rsp1_valid;
  logic [3:0]  rsp_data;
  logic        ram_en, ram_we;
  logic [11:0] ram_addr;
  logic [3:0]  ram_di, ram_do;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef X_RAMB16_ARB_SCRUB_EN
  localparam logic       EXP_BUSY_RST = 1'b1;
  localparam logic [3:0] EXP_7A5      = 4'h0;
`else
  localparam logic       EXP_BUSY_RST = 1'b0;
  localparam logic [3:0] EXP_7A5      = 4'hC;   // initial image: addr[3:0] ^ 9
`endif

  always #5 clk = ~clk;

  x_ramb16_s4_arb dut (
    .CLK        (clk),
    .SSR        (ssr),
    .REQ0_VALID (req0_valid),
    .REQ0_READY (req0_ready),
    .REQ0_WE    (req0_we),
    .REQ0_ADDR  (req0_addr),
    .REQ0_DI    (req0_di),
    .REQ1_VALID (req1_valid),
    .REQ1_READY (req1_ready),
    .REQ1_WE    (req1_we),
    .REQ1_ADDR  (req1_addr),
    .REQ1_DI    (req1_di),
    .RSP0_VALID (rsp0_valid),
    .RSP1_VALID (rsp1_valid),
    .RSP_DATA   (rsp_data),
    .RAM_EN     (ram_en),
    .RAM_WE     (ram_we),
    .RAM_ADDR   (ram_addr),
    .RAM_DI     (ram_di),
    .RAM_DO     (ram_do),
    .BUSY       (busy)
  );

  // Behavioural RAM port, write-first, one cycle read latency.
  logic [3:0] mem [0:4095];
  initial for (int i = 0; i < 4096; i++) mem[i] = i[3:0] ^ 4'h9;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      ram_do <= ram_we ? ram_di : mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic        v0, we0;
    logic [11:0] a0;
    logic [3:0]  d0;
    logic        v1, we1;
    logic [11:0] a1;
    logic [3:0]  d1;
    logic [1:0]  rdy;     // {ready0, ready1}
    logic [1:0]  rsp;     // {rsp0, rsp1}
    logic [3:0]  data;
    logic        chk_ram;
    logic        en, we;
    logic [11:0] addr;
    logic [3:0]  di;
  } vec_t;

  function automatic vec_t mk(
    input logic v0, input logic we0, input logic [11:0] a0, input logic [3:0] d0,
    input logic v1, input logic we1, input logic [11:0] a1, input logic [3:0] d1,
    input logic [1:0] rdy, input logic [1:0] rsp, input logic [3:0] data,
    input logic chk_ram, input logic en, input logic we,
    input logic [11:0] addr, input logic [3:0] di);
    vec_t v;
    v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.rdy = rdy; v.rsp = rsp; v.data = data;
    v.chk_ram = chk_ram; v.en = en; v.we = we; v.addr = addr; v.di = di;
    return v;
  endfunction

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_di = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_di = '0;
  endtask

  // Outputs while SSR is held, with both clients requesting.
  task automatic check_reset_vals();
    check("rst_ready", {req0_ready, req1_ready}, 2'b00);
    check("rst_rsp", {rsp0_valid, rsp1_valid, rsp_data}, 6'h00);
    check("rst_ram", {ram_en, ram_we, ram_addr, ram_di}, 18'h0);
    check("rst_busy", busy, EXP_BUSY_RST);
  endtask

  // Single client-0 read, checking grant, RAM command and response timing.
  task automatic read0(input logic [11:0] a, input logic [3:0] exp);
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = a; req0_di = '0;
    #1 check("rd_ready", req0_ready, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    check("rd_ram", {ram_en, ram_we, ram_addr}, {2'b10, a});
    @(negedge clk);
    @(negedge clk);
    check("rd_rsp", {rsp0_valid, rsp1_valid, rsp_data}, {2'b10, exp});
  endtask

  task automatic release_rst(input bit do_read);
    @(negedge clk);
    ssr = 1'b0;
    idle_inputs();
`ifdef X_RAMB16_ARB_SCRUB_EN
    begin
      int busy_cnt = 0;
      int wr_cnt = 0;
      int bad = 0;
      for (int c = 0; c < 5000; c++) begin
        @(negedge clk);
        if (ram_en) begin
          if (!(ram_we && ram_addr == wr_cnt[11:0] && ram_di == 4'h0)) bad++;
          wr_cnt++;
        end
        if (busy) busy_cnt++;
        else break;
      end
      check("scrub_busy_cycles", busy_cnt, 4096);
      check("scrub_writes", wr_cnt, 4096);
      check("scrub_order", bad, 0);
    end
`else
    #1 check("busy_low", busy, 1'b0);
`endif
    if (do_read) read0(12'h7A5, EXP_7A5);
  endtask

  vec_t vt [22];

  initial begin
    // Rows: inputs applied in cycle i; outputs are those visible in cycle i.
    vt[0]  = mk(1,1,12'h010,4'hC, 0,0,12'h000,4'h0, 2'b10,2'b00,4'h0, 0,0,0,12'h000,4'h0);
    vt[1]  = mk(1,0,12'h010,4'h0, 0,0,12'h000,4'h0, 2'b10,2'b00,4'h0, 1,1,1,12'h010,4'hC);
    vt[2]  = mk(1,1,12'h001,4'h5, 1,1,12'h002,4'hA, 2'b01,2'b00,4'h0, 1,1,0,12'h010,4'h0);
    vt[3]  = mk(1,1,12'h001,4'h5, 0,0,12'h000,4'h0, 2'b10,2'b00,4'h0, 1,1,1,12'h002,4'hA);
    vt[4]  = mk(1,0,12'h001,4'h0, 1,0,12'h002,4'h0, 2'b01,2'b10,4'hC, 1,1,1,12'h001,4'h5);
    vt[5]  = mk(1,0,12'h001,4'h0, 1,0,12'h002,4'h0, 2'b10,2'b00,4'hC, 1,1,0,12'h002,4'h0);
    vt[6]  = mk(1,0,12'h001,4'h0, 1,0,12'h002,4'h0, 2'b01,2'b00,4'hC, 1,1,0,12'h001,4'h0);
    vt[7]  = mk(1,0,12'h001,4'h0, 1,0,12'h002,4'h0, 2'b10,2'b01,4'hA, 1,1,0,12'h002,4'h0);
    vt[8]  = mk(0,0,12'h000,4'h0, 0,0,12'h000,4'h0, 2'b00,2'b10,4'h5, 1,1,0,12'h001,4'h0);
    vt[9]  = mk(0,0,12'h000,4'h0, 0,0,12'h000,4'h0, 2'b00,2'b01,4'hA, 1,0,0,12'h001,4'h0);
    vt[10] = mk(0,0,12'h000,4'h0, 0,0,12'h000,4'h0, 2'b00,2'b10,4'h5, 1,0,0,12'h001,4'h0);
    vt[11] = mk(0,0,12'h000,4'h0, 0,0,12'h000,4'h0, 2'b00,2'b00,4'h5, 1,0,0,12'h001,4'h0);
    vt[12] = mk(0,0,12'h000,4'h0, 1,0,12'h002,4'h0, 2'b01,2'b00,4'h5, 1,0,0,12'h001,4'h0);
    vt[13] = mk(0,0,12'h000,4'h0, 1,0,12'h002,4'h0, 2'b01,2'b00,4'h5, 1,1,0,12'h002,4'h0);
    vt[14] = mk(0,0,12'h000,4'h0, 1,0,12'h002,4'h0, 2'b01,2'b00,4'h5, 1,1,0,12'h002,4'h0);
    vt[15] = mk(0,0,12'h000,4'h0, 1,0,12'h002,4'h0, 2'b01,2'b01,4'hA, 1,1,0,12'h002,4'h0);
    vt[16] = mk(0,0,12'h000,4'h0, 1,0,12'h002,4'h0, 2'b01,2'b01,4'hA, 1,1,0,12'h002,4'h0);
    vt[17] = mk(1,0,12'h001,4'h0, 1,0,12'h002,4'h0, 2'b10,2'b01,4'hA, 1,1,0,12'h002,4'h0);
    vt[18] = mk(1,0,12'h001,4'h0, 1,0,12'h002,4'h0, 2'b01,2'b01,4'hA, 1,1,0,12'h001,4'h0);
    vt[19] = mk(0,0,12'h000,4'h0, 0,0,12'h000,4'h0, 2'b00,2'b01,4'hA, 1,1,0,12'h002,4'h0);
    vt[20] = mk(0,0,12'h000,4'h0, 0,0,12'h000,4'h0, 2'b00,2'b10,4'h5, 1,0,0,12'h002,4'h0);
    vt[21] = mk(0,0,12'h000,4'h0, 0,0,12'h000,4'h0, 2'b00,2'b01,4'hA, 1,0,0,12'h002,4'h0);

    // Reset with both clients requesting: nothing may be granted.
    ssr = 1'b1;
    idle_inputs();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals();

    // Leave reset (scrub when enabled), then read back 12'h7A5.
    release_rst(1'b1);

    // Read accepted at E, SSR at E+1: the read must never respond.
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 12'h7A5;
    #1 check("abort_ready", req0_ready, 1'b1);
    @(negedge clk);
    ssr = 1'b1;
    req1_valid = 1'b1;
    begin
      int pulses = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (rsp0_valid || rsp1_valid) pulses++;
      end
      check("abort_no_rsp", pulses, 0);
    end
    check_reset_vals();
    release_rst(1'b1);

    // Fresh reset so the pointer favours client 0 and RSP_DATA is 0.
    @(negedge clk);
    ssr = 1'b1;
    repeat (2) @(negedge clk);
    release_rst(1'b0);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      req0_valid = vt[i].v0; req0_we = vt[i].we0; req0_addr = vt[i].a0; req0_di = vt[i].d0;
      req1_valid = vt[i].v1; req1_we = vt[i].we1; req1_addr = vt[i].a1; req1_di = vt[i].d1;
      #1;
      check($sformatf("vec%0d_out", i),
            {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data},
            {vt[i].rdy, vt[i].rsp, vt[i].data});
      if (vt[i].chk_ram)
        check($sformatf("vec%0d_ram", i),
              {ram_en, ram_we, ram_addr, ram_di},
              {vt[i].en, vt[i].we, vt[i].addr, vt[i].di});
    end
    idle_inputs();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
